// File: rtl/usr_pkg.sv
// +------------------------------------------------------------------+
// | usr_pkg : mode select encodings shared by the universal shift reg |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package usr_pkg;

   localparam logic [1:0] SEL_HOLD = 2'd0;
   localparam logic [1:0] SEL_SHR  = 2'd1;
   localparam logic [1:0] SEL_SHL  = 2'd2;
   localparam logic [1:0] SEL_LOAD = 2'd3;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_cell.sv
// +------------------------------------------------------------------+
// | usr_cell : per-bit 4:1 next-state mux of the universal shift reg  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module usr_cell
   import usr_pkg::*;
(
   input  logic [1:0] sel_i,
   input  logic       hold_i,
   input  logic       msb_side_i,
   input  logic       lsb_side_i,
   input  logic       par_i,
   output logic       d_o
);

   // A right shift pulls from the more-significant neighbour, a left shift
   // from the less-significant one.
   always_comb begin
      d_o = hold_i;
      case (sel_i)
         SEL_HOLD: d_o = hold_i;
         SEL_SHR:  d_o = msb_side_i;
         SEL_SHL:  d_o = lsb_side_i;
         SEL_LOAD: d_o = par_i;
         default:  d_o = hold_i;
      endcase
   end

endmodule : usr_cell

`default_nettype wire

// File: rtl/usr.sv
// +------------------------------------------------------------------+
// | usr : WIDTH-bit universal shift register (hold/shr/shl/load)      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module usr
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       select,
   input  logic [WIDTH-1:0] p_din,
   input  logic             s_left_din,
   input  logic             s_right_din,
   output logic [WIDTH-1:0] p_dout,
   output logic             s_left_dout,
   output logic             s_right_dout
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Register padded with the serial inputs so every cell sees uniform neighbours.
   logic [WIDTH+1:0] ext_w;
   assign ext_w = {s_right_din, q_q, s_left_din};

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         usr_cell u_cell (
            .sel_i      (select),
            .hold_i     (q_q[i]),
            .msb_side_i (ext_w[i+2]),
            .lsb_side_i (ext_w[i]),
            .par_i      (p_din[i]),
            .d_o        (q_d[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign p_dout       = q_q;
   assign s_left_dout  = q_q[WIDTH-1];
   assign s_right_dout = q_q[0];

endmodule : usr

`default_nettype wire

// File: tb/tb_usr.sv
// +------------------------------------------------------------------+
// | tb_usr : directed and model-compared bench for usr (WIDTH 4 and 8) |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_usr;

   logic       clk;
   logic       rst_n;
   logic [1:0] select;
   logic [3:0] p_din4;
   logic [7:0] p_din8;
   logic       s_left_din;
   logic       s_right_din;
   logic [3:0] p_dout4;
   logic [7:0] p_dout8;
   logic       sl4, sr4, sl8, sr8;

   int checks = 0;
   int errors = 0;

   usr #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .select(select), .p_din(p_din4),
      .s_left_din(s_left_din), .s_right_din(s_right_din),
      .p_dout(p_dout4), .s_left_dout(sl4), .s_right_dout(sr4)
   );

   usr #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .select(select), .p_din(p_din8),
      .s_left_din(s_left_din), .s_right_din(s_right_din),
      .p_dout(p_dout8), .s_left_dout(sl8), .s_right_dout(sr8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string name, input logic [3:0] exp_q,
                       input logic exp_sl, input logic exp_sr);
      checks++;
      if (p_dout4 !== exp_q || sl4 !== exp_sl || sr4 !== exp_sr) begin
         errors++;
         $display("FAIL %s: got q=%b sl=%b sr=%b, want q=%b sl=%b sr=%b",
                  name, p_dout4, sl4, sr4, exp_q, exp_sl, exp_sr);
      end
   endtask

   task automatic load4(input logic [3:0] v);
      select = 2'd3;
      p_din4 = v;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; select = 2'd3; p_din4 = 4'b1111; p_din8 = 8'hFF;
      s_left_din = 1'b1; s_right_din = 1'b1;
      #2;
      chk4("reset_t0", 4'b0000, 1'b0, 1'b0);
      tick();
      tick();
      chk4("reset_overrides_load", 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk4("first_edge_after_release", 4'b1111, 1'b1, 1'b1);
   endtask

   task automatic test_load_shr();
      load4(4'b1101);
      chk4("load_1101", 4'b1101, 1'b1, 1'b1);
      select = 2'd1; s_right_din = 1'b0;
      tick(); chk4("shr_1", 4'b0110, 1'b0, 1'b0);
      tick(); chk4("shr_2", 4'b0011, 1'b0, 1'b1);
      tick(); chk4("shr_3", 4'b0001, 1'b0, 1'b1);
      s_right_din = 1'b1;
      tick(); chk4("shr_in_1", 4'b1000, 1'b1, 1'b0);
   endtask

   task automatic test_shl();
      load4(4'b1101);
      select = 2'd2; s_left_din = 1'b1;
      tick(); chk4("shl_1", 4'b1011, 1'b1, 1'b1);
      tick(); chk4("shl_2", 4'b0111, 1'b0, 1'b1);
      tick(); chk4("shl_3", 4'b1111, 1'b1, 1'b1);
      s_left_din = 1'b0;
      tick(); chk4("shl_in_0", 4'b1110, 1'b1, 1'b0);
   endtask

   task automatic test_hold();
      load4(4'b1011);
      select = 2'd0;
      for (int i = 0; i < 5; i++) begin
         p_din4 = 4'(i * 5 + 2);
         s_left_din = i[0];
         s_right_din = ~i[0];
         tick();
         chk4("hold", 4'b1011, 1'b1, 1'b1);
      end
   endtask

   task automatic test_async_reset();
      load4(4'b1101);
      select = 2'd1; s_right_din = 1'b0;
      tick();
      chk4("pre_reset_shift", 4'b0110, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk4("async_clear", 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      select = 2'd3; p_din4 = 4'b0110;
      tick();
      chk4("load_after_reset", 4'b0110, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] m4;
      logic [7:0] m8;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m4 = '0;
      m8 = '0;
      for (int n = 0; n < 300; n++) begin
         select      = 2'($urandom_range(0, 3));
         p_din4      = 4'($urandom);
         p_din8      = 8'($urandom);
         s_left_din  = 1'($urandom);
         s_right_din = 1'($urandom);
         case (select)
            2'd1: begin
               m4 = {s_right_din, m4[3:1]};
               m8 = {s_right_din, m8[7:1]};
            end
            2'd2: begin
               m4 = {m4[2:0], s_left_din};
               m8 = {m8[6:0], s_left_din};
            end
            2'd3: begin
               m4 = p_din4;
               m8 = p_din8;
            end
            default: ;
         endcase
         tick();
         chk4("rand_w4", m4, m4[3], m4[0]);
         checks++;
         if (p_dout8 !== m8 || sl8 !== m8[7] || sr8 !== m8[0]) begin
            errors++;
            $display("FAIL rand_w8 cycle %0d: got q=%h sl=%b sr=%b, want q=%h",
                     n, p_dout8, sl8, sr8, m8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_shr();
      test_shl();
      test_hold();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_usr

`default_nettype wire

// File: doc/usr.md
USR -- requirements
Module: usr

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits (minimum 2).
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 select  input  2  mode select: 0 hold, 1 shift right, 2 shift left, 3 parallel load.
REQ-005 p_din  input  WIDTH  parallel data in.
REQ-006 s_left_din  input  1  serial in for left shift; enters at bit 0.
REQ-007 s_right_din  input  1  serial in for right shift; enters at bit WIDTH-1.
REQ-008 p_dout  output  WIDTH  parallel data out; the register contents.
REQ-009 s_left_dout  output  1  serial out for left shift; equals p_dout[WIDTH-1].
REQ-010 s_right_dout  output  1  serial out for right shift; equals p_dout[0].
REQ-011 Ports SHALL be positional in this order: clk, rst_n, select, p_din, s_left_din, s_right_din, p_dout, s_left_dout, s_right_dout.

Function
REQ-012 The block SHALL hold one WIDTH-bit register Q, updated only on the rising clk edge while rst_n=1.
REQ-013 select=0 (hold): Q SHALL keep its value.
REQ-014 select=1 (shift right): Q SHALL become {s_right_din, Q[WIDTH-1:1]}.
REQ-015 select=2 (shift left): Q SHALL become {Q[WIDTH-2:0], s_left_din}.
REQ-016 select=3 (load): Q SHALL become p_din.
REQ-017 Every operation SHALL take effect with 1-cycle latency; new p_dout is visible after the edge that samples select.
REQ-018 p_dout SHALL equal Q; s_left_dout and s_right_dout SHALL be combinational taps of Q, with no extra register stage.
REQ-019 select, p_din and serial inputs containing X/Z SHALL NOT be special-cased; hold is the only mode that ignores the data inputs.
REQ-020 The block SHALL have no handshake; every enabled edge applies exactly one operation.

Reset
REQ-021 rst_n=0 SHALL clear Q to all zeros immediately, without waiting for a clock edge, so p_dout=0, s_left_dout=0 and s_right_dout=0.
REQ-022 Reset SHALL override every select mode, including reset asserted mid-shift.
REQ-023 The first operation after reset release SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-024 Select encodings SHALL be named constants in a shared package (usr_pkg): SEL_HOLD=0, SEL_SHR=1, SEL_SHL=2, SEL_LOAD=3.
REQ-025 The per-bit 4:1 next-state mux SHALL be a sub-module, usr_cell, instantiated WIDTH times; usr_cell selects from hold, left neighbour, right neighbour and parallel bit.
REQ-026 Edge cells SHALL take s_right_din (bit WIDTH-1) and s_left_din (bit 0) as their neighbour inputs.

Verification
REQ-027 Reset: rst_n=0 at t=0 -> p_dout=0000, both serial outs 0 before any clock edge.
REQ-028 Load then right shift: select=3, p_din=1101 -> p_dout=1101, s_left_dout=1, s_right_dout=1; then select=1, s_right_din=0 -> 0110, then 0011, then 0001.
REQ-029 Left shift: load 1101, then select=2, s_left_din=1 -> 1011, then 0111, then 1111; s_left_dout tracks bit 3 each cycle.
REQ-030 Hold: after loading 1011, select=0 for 5 cycles with p_din and serial inputs toggling -> p_dout stays 1011.
REQ-031 Async reset mid-operation: while shifting, drop rst_n between edges -> p_dout=0000 immediately; after release, select=3, p_din=0110 -> 0110 on the next edge.
REQ-032 Bench SHALL compare every cycle against a reference model, for WIDTH=4 and WIDTH=8, under random select/data stimulus.
